// File: rtl/temporizador_pkg.sv
// Shared types for the multichannel seconds timer.
// State encoding and channel mode constants.
package temporizador_pkg;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CONTANDO = 2'd1,
    EXPIRADO = 2'd2
  } estado_t;

  localparam logic MODO_UNICO     = 1'b0;
  localparam logic MODO_PERIODICO = 1'b1;

endpackage

// File: rtl/temporizador_canal.sv
// One timer channel: one-shot or periodic count of the tick strobe.
// All outputs come straight from registers.
module temporizador_canal
  import temporizador_pkg::*;
#(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             inicio,
  input  logic             detener,
  input  logic             modo,
  input  logic [ANCHO-1:0] limite,
  output logic [ANCHO-1:0] conteo,
  output logic             activo,
  output logic             expiro,
  output logic             pulso_exp
);

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] conteo_q, conteo_d;
  logic [ANCHO-1:0] lim_q, lim_d;
  logic             modo_q, modo_d;
  logic             expiro_q, expiro_d;
  logic             pulso_q, pulso_d;
  logic [ANCHO-1:0] siguiente;

  assign siguiente = conteo_q + ANCHO'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= INACTIVO;
      conteo_q <= '0;
      lim_q    <= '0;
      modo_q   <= MODO_UNICO;
      expiro_q <= 1'b0;
      pulso_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      conteo_q <= conteo_d;
      lim_q    <= lim_d;
      modo_q   <= modo_d;
      expiro_q <= expiro_d;
      pulso_q  <= pulso_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    conteo_d = conteo_q;
    lim_d    = lim_q;
    modo_d   = modo_q;
    expiro_d = expiro_q;
    pulso_d  = 1'b0;
    if (inicio) begin
      lim_d    = limite;
      conteo_d = '0;
      // A zero limit would pulse every cycle if periodic
      modo_d   = (limite == '0) ? MODO_UNICO : modo;
      if (limite == '0) begin
        estado_d = EXPIRADO;
        expiro_d = 1'b1;
        pulso_d  = 1'b1;
      end else begin
        estado_d = CONTANDO;
        expiro_d = 1'b0;
      end
    end else if (detener) begin
      estado_d = INACTIVO;
      expiro_d = 1'b0;
    end else if (tick && estado_q == CONTANDO) begin
      if (siguiente == lim_q) begin
        pulso_d = 1'b1;
        if (modo_q == MODO_PERIODICO) begin
          conteo_d = '0;
        end else begin
          conteo_d = siguiente;
          estado_d = EXPIRADO;
          expiro_d = 1'b1;
        end
      end else begin
        conteo_d = siguiente;
      end
    end
  end

  assign conteo    = conteo_q;
  assign activo    = (estado_q == CONTANDO);
  assign expiro    = expiro_q;
  assign pulso_exp = pulso_q;

endmodule

// File: rtl/temporizador_multicanal.sv
// CANALES independent seconds timers sharing one tick strobe.
// Only slicing and packing happen here.
module temporizador_multicanal #(
  parameter int ANCHO   = 4,
  parameter int CANALES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [CANALES-1:0]       inicio,
  input  logic [CANALES-1:0]       detener,
  input  logic [CANALES-1:0]       modo,
  input  logic [CANALES*ANCHO-1:0] limite,
  output logic [CANALES*ANCHO-1:0] conteo,
  output logic [CANALES-1:0]       activo,
  output logic [CANALES-1:0]       expiro,
  output logic [CANALES-1:0]       pulso_exp
);

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    temporizador_canal #(
      .ANCHO(ANCHO)
    ) u_canal (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .inicio   (inicio[i]),
      .detener  (detener[i]),
      .modo     (modo[i]),
      .limite   (limite[i*ANCHO +: ANCHO]),
      .conteo   (conteo[i*ANCHO +: ANCHO]),
      .activo   (activo[i]),
      .expiro   (expiro[i]),
      .pulso_exp(pulso_exp[i])
    );
  end

endmodule

// File: tb/tb_temporizador_multicanal.sv
// Bench for temporizador_multicanal: directed scenarios plus
// random traffic against a behavioural channel model.
module tb_temporizador_multicanal;

  localparam int A = 4;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick = 1'b0;
  logic [C-1:0]   inicio = '0;
  logic [C-1:0]   detener = '0;
  logic [C-1:0]   modo = '0;
  logic [C*A-1:0] limite = '0;
  logic [C*A-1:0] conteo;
  logic [C-1:0]   activo;
  logic [C-1:0]   expiro;
  logic [C-1:0]   pulso_exp;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt [C];
  int m_lim [C];
  bit m_per [C];
  bit m_run [C];
  bit m_exp [C];
  bit m_pul [C];

  temporizador_multicanal #(.ANCHO(A), .CANALES(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .inicio   (inicio),
    .detener  (detener),
    .modo     (modo),
    .limite   (limite),
    .conteo   (conteo),
    .activo   (activo),
    .expiro   (expiro),
    .pulso_exp(pulso_exp)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_cnt[i] = 0; m_lim[i] = 0; m_per[i] = 0;
      m_run[i] = 0; m_exp[i] = 0; m_pul[i] = 0;
    end
  endtask

  task automatic model_edge();
    int lm;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < C; i++) begin
      m_pul[i] = 0;
      lm = int'(limite[i*A +: A]);
      if (inicio[i]) begin
        m_lim[i] = lm;
        m_per[i] = modo[i] && lm != 0;
        m_cnt[i] = 0;
        m_run[i] = lm != 0;
        m_exp[i] = lm == 0;
        m_pul[i] = lm == 0;
      end else if (detener[i]) begin
        m_run[i] = 0;
        m_exp[i] = 0;
      end else if (tick && m_run[i]) begin
        if (m_cnt[i] + 1 == m_lim[i]) begin
          m_pul[i] = 1;
          if (m_per[i]) m_cnt[i] = 0;
          else begin
            m_cnt[i] = m_lim[i];
            m_run[i] = 0;
            m_exp[i] = 1;
          end
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  function automatic logic [C*A-1:0] e_conteo();
    logic [C*A-1:0] r;
    for (int i = 0; i < C; i++) r[i*A +: A] = A'(m_cnt[i]);
    return r;
  endfunction

  function automatic logic [C-1:0] e_bits(input int sel);
    logic [C-1:0] r;
    for (int i = 0; i < C; i++)
      r[i] = (sel == 0) ? m_run[i] : (sel == 1) ? m_exp[i] : m_pul[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    inicio = '0;
    detener = '0;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick = 1'($urandom); inicio = C'($urandom);
      detener = C'($urandom); modo = C'($urandom);
      limite = (C*A)'($urandom);
      step();
      vectors++;
      if ({conteo, activo, expiro, pulso_exp} !== '0) begin
        miscompares++;
        $display("FAIL reset_outs got %h want 0",
                 {conteo, activo, expiro, pulso_exp});
      end
    end
    idle();
    #2 rst_n = 1'b1;
    step();
    limite[0 +: A] = 3; modo[0] = 0; inicio[0] = 1;
    step();
    idle();
    vectors++;
    if (activo[0] !== 1'b1 || conteo[0 +: A] !== 0) begin
      miscompares++;
      $display("FAIL start_ch0 got act=%b cnt=%0d want 1/0",
               activo[0], conteo[0 +: A]);
    end
    for (int k = 1; k <= 3; k++) begin
      tick = 1; step(); tick = 0;
      vectors++;
      if (conteo[0 +: A] !== A'(k) || pulso_exp[0] !== (k == 3) ||
          expiro[0] !== (k == 3)) begin
        miscompares++;
        $display("FAIL oneshot_t%0d got cnt=%0d p=%b e=%b want %0d/%b/%b",
                 k, conteo[0 +: A], pulso_exp[0], expiro[0], k, k == 3, k == 3);
      end
    end
    step();
    vectors++;
    if (pulso_exp[0] !== 0 || expiro[0] !== 1 || conteo[0 +: A] !== 3) begin
      miscompares++;
      $display("FAIL oneshot_hold got p=%b e=%b cnt=%0d want 0/1/3",
               pulso_exp[0], expiro[0], conteo[0 +: A]);
    end
  endtask

  task automatic test_periodico();
    limite[A +: A] = 2; modo[1] = 1; inicio[1] = 1;
    step();
    idle();
    for (int k = 1; k <= 6; k++) begin
      tick = 1; step(); tick = 0;
      vectors++;
      if (conteo[A +: A] !== A'(k % 2) || pulso_exp[1] !== (k % 2 == 0) ||
          expiro[1] !== 0 || activo[1] !== 1) begin
        miscompares++;
        $display("FAIL periodic_t%0d got cnt=%0d p=%b e=%b a=%b want %0d/%b/0/1",
                 k, conteo[A +: A], pulso_exp[1], expiro[1], activo[1],
                 k % 2, k % 2 == 0);
      end
    end
  endtask

  task automatic test_limite_cero();
    limite[0 +: A] = 0; modo[0] = 1; inicio[0] = 1;
    step();
    idle();
    vectors++;
    if (pulso_exp[0] !== 1 || expiro[0] !== 1 || conteo[0 +: A] !== 0 ||
        activo[0] !== 0) begin
      miscompares++;
      $display("FAIL lim0_start got p=%b e=%b cnt=%0d a=%b want 1/1/0/0",
               pulso_exp[0], expiro[0], conteo[0 +: A], activo[0]);
    end
    for (int k = 0; k < 3; k++) begin
      tick = 1; step(); tick = 0;
      vectors++;
      if (pulso_exp[0] !== 0 || expiro[0] !== 1) begin
        miscompares++;
        $display("FAIL lim0_tick%0d got p=%b e=%b want 0/1",
                 k, pulso_exp[0], expiro[0]);
      end
    end
  endtask

  task automatic test_colisiones();
    limite[0 +: A] = 3; modo[0] = 0; inicio[0] = 1;
    step(); idle();
    tick = 1; step(); step(); tick = 0;
    inicio[0] = 1; tick = 1;
    step(); idle();
    vectors++;
    if (conteo[0 +: A] !== 0 || activo[0] !== 1) begin
      miscompares++;
      $display("FAIL ini_tick got cnt=%0d a=%b want 0/1",
               conteo[0 +: A], activo[0]);
    end
    inicio[0] = 1; detener[0] = 1;
    step(); idle();
    vectors++;
    if (activo[0] !== 1) begin
      miscompares++;
      $display("FAIL ini_det got a=%b want 1", activo[0]);
    end
    tick = 1; step(); step(); tick = 0;
    detener[0] = 1; tick = 1;
    step(); idle();
    vectors++;
    if (conteo[0 +: A] !== 2 || activo[0] !== 0 || pulso_exp[0] !== 0 ||
        expiro[0] !== 0) begin
      miscompares++;
      $display("FAIL det_tick got cnt=%0d a=%b p=%b e=%b want 2/0/0/0",
               conteo[0 +: A], activo[0], pulso_exp[0], expiro[0]);
    end
  endtask

  task automatic test_reset_medio();
    limite[0 +: A] = 9; modo[0] = 0; inicio[0] = 1;
    limite[A +: A] = 1; modo[1] = 0; inicio[1] = 1;
    step(); idle();
    for (int k = 0; k < 5; k++) begin
      tick = 1; step();
    end
    tick = 0;
    vectors++;
    if (conteo[0 +: A] !== 5 || activo[0] !== 1 || expiro[1] !== 1 ||
        conteo[A +: A] !== 1) begin
      miscompares++;
      $display("FAIL indep got c0=%0d a0=%b e1=%b c1=%0d want 5/1/1/1",
               conteo[0 +: A], activo[0], expiro[1], conteo[A +: A]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({conteo, activo, expiro, pulso_exp} !== '0) begin
      miscompares++;
      $display("FAIL async_rst got %h want 0",
               {conteo, activo, expiro, pulso_exp});
    end
    #2 rst_n = 1'b1;
    limite[0 +: A] = 15; modo[0] = 0; inicio[0] = 1;
    step(); idle();
    for (int k = 1; k <= 15; k++) begin
      tick = 1; step();
      vectors++;
      if (conteo[0 +: A] !== A'(k) || pulso_exp[0] !== (k == 15)) begin
        miscompares++;
        $display("FAIL lim15_t%0d got cnt=%0d p=%b want %0d/%b",
                 k, conteo[0 +: A], pulso_exp[0], k, k == 15);
      end
    end
    tick = 0;
    step();
    vectors++;
    if (conteo[0 +: A] !== 15 || expiro[0] !== 1 || activo[0] !== 0) begin
      miscompares++;
      $display("FAIL lim15_hold got cnt=%0d e=%b a=%b want 15/1/0",
               conteo[0 +: A], expiro[0], activo[0]);
    end
  endtask

  task automatic test_aleatorio();
    for (int k = 0; k < 400; k++) begin
      tick = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < C; i++) begin
        inicio[i]  = ($urandom_range(0, 15) == 0);
        detener[i] = ($urandom_range(0, 23) == 0);
      end
      modo = C'($urandom);
      for (int i = 0; i < C; i++)
        limite[i*A +: A] = ($urandom_range(0, 9) == 0) ? A'(0) : A'($urandom);
      step();
      vectors++;
      if (conteo !== e_conteo() || activo !== e_bits(0) ||
          expiro !== e_bits(1) || pulso_exp !== e_bits(2)) begin
        miscompares++;
        $display("FAIL random_%0d got c=%h a=%b e=%b p=%b want c=%h a=%b e=%b p=%b",
                 k, conteo, activo, expiro, pulso_exp,
                 e_conteo(), e_bits(0), e_bits(1), e_bits(2));
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodico();
    test_limite_cero();
    test_colisiones();
    test_reset_medio();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temporizador_multicanal.md
# temporizador_multicanal

Parametrised, fully synchronous successor to the single-channel seconds timer used by the lab state machines. It provides CANALES independent timers of ANCHO bits each. All channels count the shared one-cycle `tick` (the seconds strobe). Each channel can run one-shot or periodic, can be stopped, and reports both a level expiry flag and a one-cycle expiry pulse to the controlling FSM.

## Interface
- ANCHO, 4, counter and limit width per channel (≥ 2)
- CANALES, 2, number of independent channels (≥ 1)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- tick  in  1  one-cycle pulse per second, synchronous to clk
- inicio  in  CANALES  per-channel start pulse; clears count, latches limite/modo, arms the channel
- detener  in  CANALES  per-channel stop pulse
- modo  in  CANALES  0 = one-shot, 1 = periodic; sampled only on inicio
- limite  in  CANALES*ANCHO  expiry value; channel i at [i*ANCHO +: ANCHO]; sampled only on inicio
- conteo  out  CANALES*ANCHO  elapsed ticks per channel, same packing as limite
- activo  out  CANALES  1 while the channel is CONTANDO
- expiro  out  CANALES  level expiry flag
- pulso_exp  out  CANALES  one-cycle pulse per expiry event

## Operation
- Per-channel FSM with three states: INACTIVO, CONTANDO, EXPIRADO. Reset state is INACTIVO.
- INACTIVO on inicio:
  - if latched limite ≠ 0 → CONTANDO, conteo=0
  - if latched limite = 0 → EXPIRADO, conteo=0, pulso_exp=1 for one cycle
- CONTANDO on tick: conteo+1. When conteo+1 equals the latched limite:
  - one-shot → EXPIRADO; conteo holds limite; expiro=1
  - periodic → conteo=0; stay CONTANDO; expiro stays 0
  - both modes → pulso_exp=1 for one cycle
- EXPIRADO holds conteo and expiro until inicio (re-arm) or detener (→ INACTIVO).
- detener in any state → INACTIVO. conteo is frozen at its current value; expiro clears to 0.
- inicio in any state restarts the channel exactly as from INACTIVO. inicio therefore re-arms a running or expired channel.
- limite = 0 forces one-shot behaviour regardless of modo. This avoids a pulse every cycle.
- Arithmetic is unsigned ANCHO bits. conteo never exceeds limite ≤ 2^ANCHO−1, so no wrap occurs.
- Live changes to limite or modo have no effect until the next inicio.
- Channels are fully independent. Only tick is shared.

## Timing
- All outputs are registered. Reset values: conteo=0, activo=0, expiro=0, pulso_exp=0.
- tick sampled high at edge N → conteo, expiro and pulso_exp change right after edge N (one-edge latency).
- inicio at edge N → activo=1 and conteo=0 after edge N.
- Simultaneous events on a channel, same edge:
  - inicio + detener → inicio wins
  - inicio + tick → restart; the tick is not counted
  - detener + tick → stop; no count, no pulso_exp
- Back-to-back ticks on consecutive cycles are counted individually.
- rst_n asserted mid-count clears everything immediately (asynchronous). Release is effective at the next rising edge.

## Structure
- Package temporizador_pkg holds:
  - the state encoding (INACTIVO=2'd0, CONTANDO=2'd1, EXPIRADO=2'd2)
  - mode constants MODO_UNICO=1'b0 and MODO_PERIODICO=1'b1
- Sub-module temporizador_canal implements one channel with ANCHO as its parameter. The top level instantiates it CANALES times in a generate loop and does slicing and packing only.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release, then inicio ch0 with limite=3, one-shot, and 3 ticks → conteo 1,2,3; pulso_exp one cycle on the 3rd tick; expiro stays 1.
- Periodic: ch1 with limite=2, modo=1, and 6 ticks → pulso_exp on ticks 2, 4, 6; conteo sequence 1,0,1,0,1,0; expiro never 1.
- limite=0: inicio → pulso_exp and expiro the cycle after inicio, conteo=0. With modo=1, further ticks produce no more pulses.
- Collisions, each on one edge: inicio+tick → conteo=0; inicio+detener → activo=1; detener+tick at conteo=2, limite=3 → conteo holds 2, activo=0, no pulse.
- Reset mid-operation and independence: ch0 at conteo=5/limite=9 while ch1 is expired; pulse rst_n low between edges → all outputs 0 immediately. After release, ANCHO=4 and limite=15 reach 15 with no wrap.
